regfile_writeback: RTL and testbench

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback_pkg.sv | 16 +
 rtl/regfile_writeback_if.sv | 44 ++++
 rtl/regfile_writeback_wb_slot.sv | 34 +++
 rtl/regfile_writeback.sv | 148 ++++++++++++++
 tb/tb_regfile_writeback.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_writeback_pkg.sv
// Shared widths and source identifiers for the register-file writeback arbiter.
package regfile_writeback_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 16;
  localparam int unsigned DEF_REGADDR_WIDTH = 3;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

  function automatic src_e other_src(input src_e s);
    return (s == SRC_ALU) ? SRC_LSU : SRC_ALU;
  endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Writeback bus: ALU and LSU producer handshakes, flush, register-file write port and status.
interface regfile_writeback_if
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned REGADDR_WIDTH = DEF_REGADDR_WIDTH,
  parameter int unsigned NUM_REGS      = 1 << REGADDR_WIDTH
) ();

  logic                     alu_valid;
  logic                     alu_ready;
  logic [REGADDR_WIDTH-1:0] alu_reg;
  logic [DATA_WIDTH-1:0]    alu_data;

  logic                     lsu_valid;
  logic                     lsu_ready;
  logic [REGADDR_WIDTH-1:0] lsu_reg;
  logic [DATA_WIDTH-1:0]    lsu_data;

  logic                     flush;

  logic                     reg_write;
  logic [REGADDR_WIDTH-1:0] write_reg;
  logic [DATA_WIDTH-1:0]    write_data;
  logic [NUM_REGS-1:0]      busy;
  logic                     idle;

  modport master (
    output alu_valid, alu_reg, alu_data,
    output lsu_valid, lsu_reg, lsu_data,
    output flush,
    input  alu_ready, lsu_ready,
    input  reg_write, write_reg, write_data, busy, idle
  );

  modport slave (
    input  alu_valid, alu_reg, alu_data,
    input  lsu_valid, lsu_reg, lsu_data,
    input  flush,
    output alu_ready, lsu_ready,
    output reg_write, write_reg, write_data, busy, idle
  );

endinterface

// File: rtl/regfile_writeback_wb_slot.sv
// One-entry writeback holding register with occupied flag; refill wins over drain on the same edge.
module wb_slot #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned REGADDR_WIDTH = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     drain,
  input  logic                     flush,
  input  logic [REGADDR_WIDTH-1:0] in_reg,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     occupied,
  output logic [REGADDR_WIDTH-1:0] slot_reg,
  output logic [DATA_WIDTH-1:0]    slot_data
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occupied  <= 1'b0;
      slot_reg  <= '0;
      slot_data <= '0;
    end else if (flush) begin
      occupied <= 1'b0;
    end else if (load) begin
      occupied  <= 1'b1;
      slot_reg  <= in_reg;
      slot_data <= in_data;
    end else if (drain) begin
      occupied <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_writeback.sv
// Two-source register-file writeback arbiter: per-source slots, age/round-robin grant, busy mask.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned REGADDR_WIDTH = DEF_REGADDR_WIDTH,
  parameter int unsigned NUM_REGS      = 1 << REGADDR_WIDTH
) (
  input  logic                clk,
  input  logic                reset_n,
  regfile_writeback_if.slave  wb
);

  logic                     alu_occ, lsu_occ;
  logic [REGADDR_WIDTH-1:0] alu_q_reg, lsu_q_reg;
  logic [DATA_WIDTH-1:0]    alu_q_data, lsu_q_data;

  logic                     grant_alu, grant_lsu;
  logic                     alu_ready, lsu_ready;
  logic                     alu_load, lsu_load;

  src_e                     rr_prio;
  src_e                     older;

  logic                     reg_write_q;
  logic [REGADDR_WIDTH-1:0] write_reg_q;
  logic [DATA_WIDTH-1:0]    write_data_q;
  logic [NUM_REGS-1:0]      busy_c;

  wb_slot #(
    .DATA_WIDTH   (DATA_WIDTH),
    .REGADDR_WIDTH(REGADDR_WIDTH)
  ) u_alu_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (alu_load),
    .drain    (grant_alu),
    .flush    (wb.flush),
    .in_reg   (wb.alu_reg),
    .in_data  (wb.alu_data),
    .occupied (alu_occ),
    .slot_reg (alu_q_reg),
    .slot_data(alu_q_data)
  );

  wb_slot #(
    .DATA_WIDTH   (DATA_WIDTH),
    .REGADDR_WIDTH(REGADDR_WIDTH)
  ) u_lsu_slot (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (lsu_load),
    .drain    (grant_lsu),
    .flush    (wb.flush),
    .in_reg   (wb.lsu_reg),
    .in_data  (wb.lsu_data),
    .occupied (lsu_occ),
    .slot_reg (lsu_q_reg),
    .slot_data(lsu_q_data)
  );

  // Same destination must retire in load order; otherwise alternate sources.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!wb.flush) begin
      if (alu_occ && lsu_occ) begin
        if (alu_q_reg == lsu_q_reg) begin
          grant_alu = (older == SRC_ALU);
          grant_lsu = (older == SRC_LSU);
        end else begin
          grant_alu = (rr_prio == SRC_ALU);
          grant_lsu = (rr_prio == SRC_LSU);
        end
      end else begin
        grant_alu = alu_occ;
        grant_lsu = lsu_occ;
      end
    end
  end

  always_comb begin
    alu_ready = reset_n && !wb.flush && (!alu_occ || grant_alu);
    lsu_ready = reset_n && !wb.flush && (!lsu_occ || grant_lsu);
    alu_load  = wb.alu_valid && alu_ready;
    lsu_load  = wb.lsu_valid && lsu_ready;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_prio <= SRC_ALU;
    end else if (grant_alu) begin
      rr_prio <= SRC_LSU;
    end else if (grant_lsu) begin
      rr_prio <= SRC_ALU;
    end
  end

  // A lone load makes the other slot the older one; a joint load ranks ALU first.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      older <= SRC_ALU;
    end else if (alu_load && lsu_load) begin
      older <= SRC_ALU;
    end else if (alu_load) begin
      older <= other_src(SRC_ALU);
    end else if (lsu_load) begin
      older <= other_src(SRC_LSU);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
    end else begin
      reg_write_q <= grant_alu || grant_lsu;
      if (grant_alu) begin
        write_reg_q  <= alu_q_reg;
        write_data_q <= alu_q_data;
      end else if (grant_lsu) begin
        write_reg_q  <= lsu_q_reg;
        write_data_q <= lsu_q_data;
      end
    end
  end

  always_comb begin
    busy_c = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if ((alu_occ     && (alu_q_reg   == REGADDR_WIDTH'(r))) ||
          (lsu_occ     && (lsu_q_reg   == REGADDR_WIDTH'(r))) ||
          (reg_write_q && (write_reg_q == REGADDR_WIDTH'(r)))) begin
        busy_c[r] = 1'b1;
      end
    end
  end

  assign wb.alu_ready  = alu_ready;
  assign wb.lsu_ready  = lsu_ready;
  assign wb.reg_write  = reg_write_q;
  assign wb.write_reg  = write_reg_q;
  assign wb.write_data = write_data_q;
  assign wb.busy       = busy_c;
  assign wb.idle       = !alu_occ && !lsu_occ && !reg_write_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: directed writes queue expectations, a negedge monitor retires them.
module tb_regfile_writeback;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 3;
  localparam int unsigned NR = 8;

  logic clk;
  logic reset_n;

  regfile_writeback_if #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .NUM_REGS(NR)) bus ();

  regfile_writeback #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .wb     (bus)
  );

  typedef struct packed {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;
  int  base;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] r, input logic [DW-1:0] d);
    wr_t e;
    e.r = r;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 1'b0;
    bus.alu_reg   = '0;
    bus.alu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_reg   = '0;
    bus.lsu_data  = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.reg_write === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got r%0d=%h expected no write", bus.write_reg, bus.write_data);
      end else begin
        e = exp_q.pop_front();
        chk("write_reg", 32'(bus.write_reg), 32'(e.r));
        chk("write_data", 32'(bus.write_data), 32'(e.d));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset_n = 1'b0;
    idle_inputs();
    bus.alu_valid = 1'b1;
    bus.lsu_valid = 1'b1;
    #2;
    chk("rst_reg_write", 32'(bus.reg_write), 32'd0);
    chk("rst_write_reg", 32'(bus.write_reg), 32'd0);
    chk("rst_write_data", 32'(bus.write_data), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_idle", 32'(bus.idle), 32'd1);
    chk("rst_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("rst_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // single ALU write, r3 = 0x1234
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 3'd3;
    bus.alu_data  = 16'h1234;
    #1;
    chk("t1_alu_ready", 32'(bus.alu_ready), 32'd1);
    push(3'd3, 16'h1234);
    tick();
    idle_inputs();
    #1;
    chk("t1_busy_slot", 32'(bus.busy), 32'h08);
    chk("t1_no_write_yet", 32'(bus.reg_write), 32'd0);
    chk("t1_not_idle", 32'(bus.idle), 32'd0);
    tick();
    chk("t1_reg_write", 32'(bus.reg_write), 32'd1);
    chk("t1_busy_issue", 32'(bus.busy), 32'h08);
    tick();
    chk("t1_busy_clear", 32'(bus.busy), 32'd0);
    chk("t1_idle", 32'(bus.idle), 32'd1);

    // simultaneous different regs after reset: ALU first
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 3'd1;
    bus.alu_data  = 16'h0011;
    bus.lsu_valid = 1'b1;
    bus.lsu_reg   = 3'd2;
    bus.lsu_data  = 16'h0022;
    #1;
    chk("t2_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("t2_lsu_ready", 32'(bus.lsu_ready), 32'd1);
    push(3'd1, 16'h0011);
    push(3'd2, 16'h0022);
    tick();
    idle_inputs();
    #1;
    chk("t2_busy", 32'(bus.busy), 32'h06);
    repeat (3) tick();
    chk("t2_idle", 32'(bus.idle), 32'd1);

    // LSU r5 loads one edge before ALU r5
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 3'd1;
    bus.alu_data  = 16'h0101;
    bus.lsu_valid = 1'b1;
    bus.lsu_reg   = 3'd5;
    bus.lsu_data  = 16'hAAAA;
    push(3'd1, 16'h0101);
    push(3'd5, 16'hAAAA);
    tick();
    bus.alu_reg   = 3'd5;
    bus.alu_data  = 16'hBBBB;
    bus.lsu_valid = 1'b0;
    #1;
    chk("t3_alu_ready", 32'(bus.alu_ready), 32'd1);
    chk("t3_lsu_blocked", 32'(bus.lsu_ready), 32'd0);
    push(3'd5, 16'hBBBB);
    tick();
    idle_inputs();
    repeat (4) tick();
    chk("t3_idle", 32'(bus.idle), 32'd1);

    // same reg loaded on the same edge: ALU then LSU, even though round-robin now favours LSU
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 3'd4;
    bus.alu_data  = 16'h0001;
    bus.lsu_valid = 1'b1;
    bus.lsu_reg   = 3'd4;
    bus.lsu_data  = 16'h0002;
    push(3'd4, 16'h0001);
    push(3'd4, 16'h0002);
    tick();
    idle_inputs();
    #1;
    chk("t4_busy", 32'(bus.busy), 32'h10);
    repeat (3) tick();
    chk("t4_idle", 32'(bus.idle), 32'd1);

    // back-to-back ALU stream
    base = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.alu_valid = 1'b1;
      bus.alu_reg   = AW'(i);
      bus.alu_data  = 16'hC000 | DW'(i);
      #1;
      chk("t5_alu_ready", 32'(bus.alu_ready), 32'd1);
      push(AW'(i), 16'hC000 | DW'(i));
      tick();
    end
    idle_inputs();
    tick();
    chk("t5_writes_per_cycle", 32'(wr_cnt - base), 32'd7);
    chk("t5_last_issuing", 32'(bus.reg_write), 32'd1);
    repeat (2) tick();
    chk("t5_idle", 32'(bus.idle), 32'd1);

    // flush with both slots full and r1 already issued
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 3'd1;
    bus.alu_data  = 16'h00F1;
    bus.lsu_valid = 1'b1;
    bus.lsu_reg   = 3'd2;
    bus.lsu_data  = 16'h00F2;
    push(3'd1, 16'h00F1);
    tick();
    bus.alu_reg   = 3'd3;
    bus.alu_data  = 16'h00F3;
    bus.lsu_valid = 1'b0;
    #1;
    chk("t6_alu_ready", 32'(bus.alu_ready), 32'd1);
    tick();
    bus.flush     = 1'b1;
    bus.alu_reg   = 3'd6;
    bus.alu_data  = 16'h00F6;
    bus.lsu_valid = 1'b1;
    bus.lsu_reg   = 3'd7;
    bus.lsu_data  = 16'h00F7;
    #1;
    chk("t6_flush_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("t6_flush_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    chk("t6_issued_survives", 32'(bus.reg_write), 32'd1);
    tick();
    idle_inputs();
    #1;
    chk("t6_busy", 32'(bus.busy), 32'd0);
    chk("t6_idle", 32'(bus.idle), 32'd1);
    repeat (3) tick();

    // reset pulsed mid-stream: only the write already sampled survives
    bus.alu_valid = 1'b1;
    bus.alu_reg   = 3'd6;
    bus.alu_data  = 16'h0A01;
    push(3'd6, 16'h0A01);
    tick();
    bus.alu_reg   = 3'd7;
    bus.alu_data  = 16'h0A02;
    tick();
    bus.alu_reg   = 3'd0;
    bus.alu_data  = 16'h0A03;
    tick();
    bus.alu_valid = 1'b0;
    chk("t7_issuing", 32'(bus.reg_write), 32'd1);
    #1;
    reset_n = 1'b0;
    bus.alu_valid = 1'b1;
    bus.lsu_valid = 1'b1;
    #1;
    chk("t7_reg_write", 32'(bus.reg_write), 32'd0);
    chk("t7_write_reg", 32'(bus.write_reg), 32'd0);
    chk("t7_write_data", 32'(bus.write_data), 32'd0);
    chk("t7_busy", 32'(bus.busy), 32'd0);
    chk("t7_idle", 32'(bus.idle), 32'd1);
    chk("t7_alu_ready", 32'(bus.alu_ready), 32'd0);
    chk("t7_lsu_ready", 32'(bus.lsu_ready), 32'd0);
    repeat (2) @(posedge clk);
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) tick();
    chk("t7_idle_after", 32'(bus.idle), 32'd1);
    chk("pending_expected", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
